// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// BOOT/RUN/HALT controller.
//
// state | meaning
// BOOT  | first cycle after reset release, no capture
// RUN   | fetching; branch > halt > stall > advance
// HALT  | fetch stopped until reset
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    input  logic [31:0] inst,
    output logic [4:0]  addressIM,
    output logic [31:0] pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] idpc_nxt;
    logic [31:0] idpc4_nxt;
    logic        valid_nxt;
    logic        mis_nxt;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc + 32'd4;
    assign addressIM = pc[6:2];
    assign halted    = (state == HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            if_id_inst   <= 32'd0;
            if_id_pc     <= 32'd0;
            if_id_pc4    <= 32'd0;
            if_id_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            if_id_inst   <= inst_nxt;
            if_id_pc     <= idpc_nxt;
            if_id_pc4    <= idpc4_nxt;
            if_id_valid  <= valid_nxt;
            misalign_err <= mis_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = if_id_inst;
        idpc_nxt  = if_id_pc;
        idpc4_nxt = if_id_pc4;
        valid_nxt = if_id_valid;
        mis_nxt   = misalign_err;

        case (state)
            BOOT: begin
                state_nxt = RUN;
                valid_nxt = 1'b0;
            end
            RUN: begin
                if (branch_taken) begin
                    // Redirect always wins, even over stall; low bits are dropped.
                    pc_nxt    = {branch_target[31:2], 2'b00};
                    valid_nxt = 1'b0;
                    if (branch_target[1:0] != 2'b00) begin
                        mis_nxt = 1'b1;
                    end
                end else if (halt_req) begin
                    state_nxt = HALT;
                    valid_nxt = 1'b0;
                end else if (!stall) begin
                    inst_nxt  = inst;
                    idpc_nxt  = pc;
                    idpc4_nxt = pc_plus4;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc_plus4;
                end
            end
            HALT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = BOOT;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: table of per-edge vectors plus a short
// sequence on a second instance whose reset PC sits near the top of memory.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req;
    logic [31:0] inst, inst2;
    logic [4:0]  addressIM, addressIM2;
    logic [31:0] pc, if_id_inst, if_id_pc, if_id_pc4;
    logic [31:0] pc2, if_id_inst2, if_id_pc2, if_id_pc42;
    logic        if_id_valid, misalign_err, halted;
    logic        if_id_valid2, misalign_err2, halted2;

    logic [31:0] im [32];

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .inst(inst),
        .addressIM(addressIM), .pc(pc), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .misalign_err(misalign_err),
        .halted(halted)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .inst(inst2),
        .addressIM(addressIM2), .pc(pc2), .if_id_inst(if_id_inst2), .if_id_pc(if_id_pc2),
        .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2), .misalign_err(misalign_err2),
        .halted(halted2)
    );

    assign inst  = im[addressIM];
    assign inst2 = im[addressIM2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        halt;
        logic [31:0] pc;
        logic [31:0] idpc;
        logic [31:0] inst;
        logic        valid;
        logic        mis;
        logic        halted;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] iw(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic h, input logic [31:0] p, input logic [31:0] ip,
                       input logic [31:0] in, input logic v, input logic m, input logic hl);
        vec_t x;
        x.rst_n = r; x.stall = s; x.br = b; x.tgt = t; x.halt = h;
        x.pc = p; x.idpc = ip; x.inst = in; x.valid = v; x.mis = m; x.halted = hl;
        tbl.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                         input logic h);
        rst_n = r; stall = s; branch_taken = b; branch_target = t; halt_req = h;
        @(posedge clk);
        #1;
    endtask

    logic        captured;
    logic [31:0] exp_pc4;
    logic [31:0] exp_pc;

    initial begin
        for (int i = 0; i < 32; i++) im[i] = iw(i);
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; halt_req = 1'b0;

        // reset, boot, normal fetch, 3-cycle stall at pc=8
        add(0,0,0,32'h0,0, 32'h00,32'h00,32'h0,    0,0,0);
        add(1,0,0,32'h0,0, 32'h00,32'h00,32'h0,    0,0,0);
        add(1,0,0,32'h0,0, 32'h04,32'h00,iw(0),    1,0,0);
        add(1,0,0,32'h0,0, 32'h08,32'h04,iw(1),    1,0,0);
        add(1,1,0,32'h0,0, 32'h08,32'h04,iw(1),    1,0,0);
        add(1,1,0,32'h0,0, 32'h08,32'h04,iw(1),    1,0,0);
        add(1,1,0,32'h0,0, 32'h08,32'h04,iw(1),    1,0,0);
        add(1,0,0,32'h0,0, 32'h0C,32'h08,iw(2),    1,0,0);
        add(1,0,0,32'h0,0, 32'h10,32'h0C,iw(3),    1,0,0);
        // branch under stall, then misaligned branch kept sticky for 10 edges
        add(1,1,1,32'h40,0, 32'h40,32'h0C,iw(3),   0,0,0);
        add(1,0,0,32'h0,0,  32'h44,32'h40,iw(16),  1,0,0);
        add(1,0,1,32'h42,0, 32'h40,32'h40,iw(16),  0,1,0);
        add(1,0,0,32'h0,0,  32'h44,32'h40,iw(16),  1,1,0);
        for (int k = 0; k < 9; k++)
            add(1,0,0,32'h0,0, 32'h48 + 32'(4*k), 32'h44 + 32'(4*k), iw(17+k), 1,1,0);
        // reset clears the flag; halt at pc=12 and ignore everything afterwards
        add(0,0,0,32'h0,0, 32'h00,32'h00,32'h0,    0,0,0);
        add(1,0,0,32'h0,0, 32'h00,32'h00,32'h0,    0,0,0);
        add(1,0,0,32'h0,0, 32'h04,32'h00,iw(0),    1,0,0);
        add(1,0,0,32'h0,0, 32'h08,32'h04,iw(1),    1,0,0);
        add(1,0,0,32'h0,0, 32'h0C,32'h08,iw(2),    1,0,0);
        add(1,0,0,32'h0,1, 32'h0C,32'h08,iw(2),    0,0,1);
        add(1,0,1,32'h40,0, 32'h0C,32'h08,iw(2),   0,0,1);
        add(1,1,0,32'h0,1,  32'h0C,32'h08,iw(2),   0,0,1);
        add(1,0,1,32'h43,0, 32'h0C,32'h08,iw(2),   0,0,1);
        add(1,0,0,32'h0,0,  32'h0C,32'h08,iw(2),   0,0,1);
        // reset in HALT with noisy inputs, boot bubble, resume
        add(0,0,1,32'h40,1, 32'h00,32'h00,32'h0,   0,0,0);
        add(1,0,0,32'h0,0,  32'h00,32'h00,32'h0,   0,0,0);
        add(1,0,0,32'h0,0,  32'h04,32'h00,iw(0),   1,0,0);
        add(1,1,0,32'h0,0,  32'h04,32'h00,iw(0),   1,0,0);
        // reset mid-stall and mid-branch
        add(0,1,1,32'h42,0, 32'h00,32'h00,32'h0,   0,0,0);
        add(1,0,0,32'h0,0,  32'h00,32'h00,32'h0,   0,0,0);
        // addressIM wraps between 0x7C and 0x80
        add(1,0,1,32'h78,0, 32'h78,32'h00,32'h0,   0,0,0);
        add(1,0,0,32'h0,0,  32'h7C,32'h78,iw(30),  1,0,0);
        add(1,0,0,32'h0,0,  32'h80,32'h7C,iw(31),  1,0,0);
        add(1,0,0,32'h0,0,  32'h84,32'h80,iw(0),   1,0,0);

        captured = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].halt);
            if (!tbl[i].rst_n) captured = 1'b0;
            if (tbl[i].valid) captured = 1'b1;
            exp_pc4 = captured ? tbl[i].idpc + 32'd4 : 32'd0;
            exp_pc  = tbl[i].pc;
            chk($sformatf("v%0d.pc", i),        pc,                    tbl[i].pc);
            chk($sformatf("v%0d.addressIM", i), {27'd0, addressIM},    {27'd0, exp_pc[6:2]});
            chk($sformatf("v%0d.if_id_pc", i),  if_id_pc,              tbl[i].idpc);
            chk($sformatf("v%0d.if_id_pc4", i), if_id_pc4,             exp_pc4);
            chk($sformatf("v%0d.if_id_inst", i), if_id_inst,           tbl[i].inst);
            chk($sformatf("v%0d.valid", i),     {31'd0, if_id_valid},  {31'd0, tbl[i].valid});
            chk($sformatf("v%0d.misalign", i),  {31'd0, misalign_err}, {31'd0, tbl[i].mis});
            chk($sformatf("v%0d.halted", i),    {31'd0, halted},       {31'd0, tbl[i].halted});
        end

        // PC wrap through 2^32 on the high reset-address instance
        drive(0,0,0,32'h0,0);
        chk("wrap.reset_pc", pc2, 32'hFFFF_FFF8);
        chk("wrap.reset_halted", {31'd0, halted2}, 32'd0);
        drive(1,0,0,32'h0,0);
        chk("wrap.boot_pc", pc2, 32'hFFFF_FFF8);
        chk("wrap.boot_valid", {31'd0, if_id_valid2}, 32'd0);
        drive(1,0,0,32'h0,0);
        chk("wrap.pc_fffc", pc2, 32'hFFFF_FFFC);
        chk("wrap.idpc_fff8", if_id_pc2, 32'hFFFF_FFF8);
        chk("wrap.pc4_fffc", if_id_pc42, 32'hFFFF_FFFC);
        chk("wrap.inst30", if_id_inst2, iw(30));
        chk("wrap.valid", {31'd0, if_id_valid2}, 32'd1);
        drive(1,0,0,32'h0,0);
        chk("wrap.pc_0", pc2, 32'h0000_0000);
        chk("wrap.addr_0", {27'd0, addressIM2}, 32'd0);
        chk("wrap.idpc_fffc", if_id_pc2, 32'hFFFF_FFFC);
        chk("wrap.pc4_0", if_id_pc42, 32'h0000_0000);
        chk("wrap.inst31", if_id_inst2, iw(31));
        drive(1,0,0,32'h0,0);
        chk("wrap.pc_4", pc2, 32'h0000_0004);
        chk("wrap.inst0", if_id_inst2, iw(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 stall  input  1  hold PC and IF/ID register (hazard from downstream).
REQ-005 branch_taken  input  1  redirect fetch to branch_target.
REQ-006 branch_target  input  32  redirect byte address.
REQ-007 halt_req  input  1  stop fetching permanently until reset.
REQ-008 inst  input  32  instruction word returned combinationally by instruction memory for addressIM.
REQ-009 addressIM  output  5  word address to instruction memory, equal to pc[6:2].
REQ-010 pc  output  32  current fetch byte address.
REQ-011 if_id_inst  output  32  registered instruction for decode.
REQ-012 if_id_pc  output  32  registered address of if_id_inst.
REQ-013 if_id_pc4  output  32  registered if_id_pc + 4.
REQ-014 if_id_valid  output  1  if_id_* holds a real instruction.
REQ-015 misalign_err  output  1  sticky flag: a branch_target with [1:0] != 0 was accepted.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 FSM states BOOT, RUN, HALT; encoding free.
REQ-018 BOOT: one cycle after reset release; no IF/ID capture, if_id_valid stays 0, PC unchanged; next state RUN unconditionally.
REQ-019 RUN, per edge, priority: branch_taken > halt_req > stall > normal advance.
REQ-020 RUN normal: if_id_inst <= inst, if_id_pc <= pc, if_id_pc4 <= pc+4, if_id_valid <= 1, pc <= pc+4.
REQ-021 RUN stall (no branch, no halt): pc and all if_id_* hold.
REQ-022 RUN branch_taken: pc <= {branch_target[31:2],2'b00}; if_id_valid <= 0 (bubble); other if_id_* hold; applies even when stall is also high.
REQ-023 branch_taken with branch_target[1:0] != 0: misalign_err <= 1, remains 1 until reset; redirect still performed with low bits cleared.
REQ-024 RUN halt_req (no branch): next state HALT; if_id_valid <= 0; pc holds.
REQ-025 HALT: pc and if_id_* hold, if_id_valid = 0, halted = 1; branch_taken, stall, halt_req ignored; exit only via reset.
REQ-026 PC arithmetic modulo 2^32: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, if_id_pc4 likewise.
REQ-027 addressIM wraps with pc: pc 32'h0000_007C -> addressIM 31; pc 32'h0000_0080 -> addressIM 0.
REQ-028 Fetch latency: instruction at pc appears on if_id_inst one edge after addressIM presents it, absent stall/branch.
REQ-029 addressIM and pc are purely registered-PC derived; no combinational path from any input to addressIM.

Reset
REQ-030 rst_n low at an edge, from any state and regardless of other inputs: pc <= RESET_PC, state <= BOOT, if_id_inst/if_id_pc/if_id_pc4 <= 0, if_id_valid <= 0, misalign_err <= 0.
REQ-031 halted = 0 in BOOT and RUN; reset mid-stall, mid-branch or in HALT fully discards in-flight state.

Verification
REQ-032 Reset then 5 free-running edges, IM preloaded words 0..4 -> addressIM 0,0,1,2,3,4 across BOOT/RUN; if_id_valid rises on the 2nd edge; if_id_pc sequence 0,4,8,12; if_id_pc4 = if_id_pc+4.
REQ-033 stall high 3 edges at pc=8 -> pc stays 8, if_id_* frozen; stall low -> fetch resumes at 8 with no skipped or duplicated instruction.
REQ-034 branch_taken with target 32'h40 while stall=1 -> next pc 32'h40, addressIM 16, if_id_valid 0 for exactly one edge, then inst at 16 captured.
REQ-035 branch_target 32'h42 -> pc 32'h40, misalign_err 1 and still 1 after 10 further edges; cleared by rst_n.
REQ-036 halt_req one cycle at pc=12 -> halted 1, pc 12 frozen, if_id_valid 0, later branch_taken ignored; RESET_PC=32'hFFFF_FFF8 run -> pc wraps FFF8, FFFC, 0000_0000.
REQ-037 rst_n low one edge during HALT -> pc = RESET_PC, halted 0, BOOT bubble, then normal fetch.
